// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the instruction and data channels.
// Issue-order ID FIFO steers in-order responses back to the channel that issued them.
//
// state | meaning
// IDLE  | free to pick a winner each cycle; selection is combinational
// LOCK  | address phase stalled by memory; selection frozen to lock_id
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int DATA_STREAK = 4
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [3:0]                   inst_wstrb,
    input  logic [31:0]                  inst_addr,
    input  logic [31:0]                  inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [31:0]                  inst_rdata,

    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [3:0]                   data_wstrb,
    input  logic [31:0]                  data_addr,
    input  logic [31:0]                  data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [31:0]                  data_rdata,

    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,

    output logic [$clog2(OUTST_DEPTH):0] outst_cnt,
    output logic                         resp_err
);

    localparam int AW = $clog2(OUTST_DEPTH);
    localparam int SW = $clog2(DATA_STREAK + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(OUTST_DEPTH);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic          lock_id;
    logic [SW-1:0] streak;
    logic          id_mem [OUTST_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    logic sel;
    logic contend;
    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic head;

    assign contend = inst_req & data_req;
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);

    // Request is gated by resetn so the shared port is quiet while reset is held.
    always_comb begin
        sel     = ID_INST;
        mem_req = 1'b0;
        if (state == LOCK) begin
            sel     = lock_id;
            mem_req = 1'b1;
        end else if (!full && (inst_req || data_req)) begin
            mem_req = 1'b1;
            if (contend)
                sel = (streak == STREAK_MAX) ? ID_INST : ID_DATA;
            else
                sel = data_req ? ID_DATA : ID_INST;
        end
        mem_req = mem_req & resetn;
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (sel == ID_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (sel == ID_INST);
    assign data_addr_ok = accept & (sel == ID_DATA);

    assign head         = id_mem[rd_ptr];
    assign pop          = mem_data_ok & ~empty;
    assign inst_data_ok = pop & (head == ID_INST);
    assign data_data_ok = pop & (head == ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;
    assign outst_cnt    = cnt;

    always_ff @(posedge clk) begin
        if (accept)
            id_mem[wr_ptr] <= sel;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lock_id  <= ID_INST;
            streak   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state   <= LOCK;
                        lock_id <= sel;
                    end
                end
                LOCK: begin
                    if (mem_addr_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Only contended data grants build the streak; any inst grant clears it.
            if (accept) begin
                if (sel == ID_INST)
                    streak <= '0;
                else if (contend && streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end

            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (mem_data_ok && empty)
                resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, streak fairness, lock, full FIFO,
// response routing and reset behaviour.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [2:0]  outst_cnt;
    logic        resp_err;

    int errs   = 0;
    int checks = 0;

    sram_req_arbiter #(.OUTST_DEPTH(4), .DATA_STREAK(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        #3;
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (inst_addr_ok !== 1'b0) begin errs++; $display("FAIL reset_inst_addr_ok got %b want 0", inst_addr_ok); end
        checks++; if (outst_cnt !== 3'd0) begin errs++; $display("FAIL reset_outst_cnt got %0d want 0", outst_cnt); end
        checks++; if (resp_err !== 1'b0) begin errs++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h/%h want 0/0", inst_rdata, data_rdata); end
        tick();
        idle_inputs();
        resetn = 1;
        tick();
    endtask

    task automatic test_inst_read();
        inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        #2;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000) begin errs++; $display("FAIL inst_issue got req=%b addr=%h want 1/bfc00000", mem_req, mem_addr); end
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errs++; $display("FAIL inst_addr_ok got %b/%b want 1/0", inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1C80_0000;
        #2;
        checks++; if (outst_cnt !== 3'd1) begin errs++; $display("FAIL inst_outst got %0d want 1", outst_cnt); end
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h1C80_0000) begin errs++; $display("FAIL inst_resp got ok=%b rdata=%h want 1/1c800000", inst_data_ok, inst_rdata); end
        checks++; if (data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin errs++; $display("FAIL inst_resp_other got ok=%b rdata=%h want 0/0", data_data_ok, data_rdata); end
        tick();
        mem_data_ok = 0;
        #2;
        checks++; if (outst_cnt !== 3'd0) begin errs++; $display("FAIL inst_drain got %0d want 0", outst_cnt); end
    endtask

    task automatic test_contention();
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_addr = 32'h0000_1000; data_wr = 1; data_wstrb = 4'hF;
        data_wdata = 32'hCAFE_F00D; data_size = 2'd2;
        mem_addr_ok = 1;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errs++; $display("FAIL cont_first got d=%b i=%b want 1/0", data_addr_ok, inst_addr_ok); end
        checks++; if (mem_addr !== 32'h0000_1000 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL cont_fields got addr=%h wr=%b strb=%h wdata=%h", mem_addr, mem_wr, mem_wstrb, mem_wdata); end
        tick();
        data_req = 0; data_wr = 0; data_wstrb = 4'h0;
        mem_data_ok = 1; mem_rdata = 32'h0000_D0D0;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'hBFC0_0004 || mem_wr !== 1'b0) begin errs++; $display("FAIL cont_second got ok=%b addr=%h wr=%b", inst_addr_ok, mem_addr, mem_wr); end
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errs++; $display("FAIL cont_resp1 got d=%b i=%b want 1/0", data_data_ok, inst_data_ok); end
        checks++; if (outst_cnt !== 3'd1) begin errs++; $display("FAIL cont_outst got %0d want 1", outst_cnt); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_rdata = 32'h0000_1111;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_1111 || data_data_ok !== 1'b0) begin errs++; $display("FAIL cont_resp2 got i=%b rdata=%h d=%b", inst_data_ok, inst_rdata, data_data_ok); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_streak();
        logic [9:0] pat;
        pat = 10'b01111_01111;   // bit i: 1 = data granted in cycle i
        do_reset();
        inst_addr = 32'hBFC0_0100;
        data_addr = 32'h0000_2000;
        for (int i = 0; i < 10; i++) begin
            inst_req = 1; data_req = 1; mem_addr_ok = 1;
            mem_data_ok = (i > 0); mem_rdata = 32'(i);
            #2;
            checks++; if (data_addr_ok !== pat[i] || inst_addr_ok !== ~pat[i]) begin errs++; $display("FAIL streak_grant[%0d] got d=%b i=%b want d=%b", i, data_addr_ok, inst_addr_ok, pat[i]); end
            if (i > 0) begin
                checks++; if (data_data_ok !== pat[i-1] || inst_data_ok !== ~pat[i-1]) begin errs++; $display("FAIL streak_resp[%0d] got d=%b i=%b want d=%b", i, data_data_ok, inst_data_ok, pat[i-1]); end
            end
            tick();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || outst_cnt !== 3'd1) begin errs++; $display("FAIL streak_tail got i=%b cnt=%0d want 1/1", inst_data_ok, outst_cnt); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'hBFC0_0010; mem_addr_ok = 0;
        #2;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0010) begin errs++; $display("FAIL lock_c1 got req=%b addr=%h", mem_req, mem_addr); end
        tick();
        data_req = 1; data_addr = 32'h0000_2000;
        #2;
        checks++; if (mem_addr !== 32'hBFC0_0010 || data_addr_ok !== 1'b0) begin errs++; $display("FAIL lock_c2 got addr=%h d_ok=%b want bfc00010/0", mem_addr, data_addr_ok); end
        tick();
        #2;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0010) begin errs++; $display("FAIL lock_c3 got req=%b addr=%h", mem_req, mem_addr); end
        tick();
        mem_addr_ok = 1;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'hBFC0_0010) begin errs++; $display("FAIL lock_accept got i=%b d=%b addr=%h", inst_addr_ok, data_addr_ok, mem_addr); end
        tick();
        inst_req = 0;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h0000_2000) begin errs++; $display("FAIL lock_after got d=%b addr=%h want 1/00002000", data_addr_ok, mem_addr); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errs++; $display("FAIL lock_resp1 got i=%b d=%b want 1/0", inst_data_ok, data_data_ok); end
        tick();
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errs++; $display("FAIL lock_resp2 got d=%b i=%b want 1/0", data_data_ok, inst_data_ok); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_full();
        inst_addr = 32'hBFC0_0200;
        for (int i = 0; i < 4; i++) begin
            inst_req = 1; mem_addr_ok = 1;
            #2;
            checks++; if (inst_addr_ok !== 1'b1) begin errs++; $display("FAIL full_fill[%0d] got %b want 1", i, inst_addr_ok); end
            tick();
        end
        data_req = 1;
        #2;
        checks++; if (mem_req !== 1'b0 || outst_cnt !== 3'd4) begin errs++; $display("FAIL full_block got req=%b cnt=%0d want 0/4", mem_req, outst_cnt); end
        checks++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin errs++; $display("FAIL full_addr_ok got i=%b d=%b want 0/0", inst_addr_ok, data_addr_ok); end
        tick();
        data_req = 0; mem_data_ok = 1;
        #2;
        checks++; if (mem_req !== 1'b0 || inst_data_ok !== 1'b1) begin errs++; $display("FAIL full_nobypass got req=%b i_ok=%b want 0/1", mem_req, inst_data_ok); end
        tick();
        mem_data_ok = 0;
        #2;
        checks++; if (outst_cnt !== 3'd3 || mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errs++; $display("FAIL full_resume got cnt=%0d req=%b ok=%b want 3/1/1", outst_cnt, mem_req, inst_addr_ok); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        tick();
        mem_data_ok = 0;
        #2;
        checks++; if (outst_cnt !== 3'd2) begin errs++; $display("FAIL full_drain got %0d want 2", outst_cnt); end
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'hBFC0_0300; mem_addr_ok = 1;
        #2;
        resetn = 0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin errs++; $display("FAIL rmid_cnt got %0d want 0", outst_cnt); end
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || inst_addr_ok !== 1'b0) begin errs++; $display("FAIL rmid_outputs got req=%b addr=%h ok=%b", mem_req, mem_addr, inst_addr_ok); end
        tick();
        idle_inputs();
        resetn = 1;
        tick();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #2;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errs++; $display("FAIL late_resp got i=%b d=%b want 0/0", inst_data_ok, data_data_ok); end
        tick();
        mem_data_ok = 0;
        #2;
        checks++; if (resp_err !== 1'b1) begin errs++; $display("FAIL resp_err_set got %b want 1", resp_err); end
        tick();
        tick();
        checks++; if (resp_err !== 1'b1 || outst_cnt !== 3'd0) begin errs++; $display("FAIL resp_err_sticky got err=%b cnt=%0d want 1/0", resp_err, outst_cnt); end
        resetn = 0;
        #1;
        checks++; if (resp_err !== 1'b0) begin errs++; $display("FAIL resp_err_clear got %b want 0", resp_err); end
        tick();
        resetn = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_contention();
        test_streak();
        test_lock();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
